heartbeat_monitor: RTL and testbench
====================================

Name: heartbeat_monitor

Overview:
- Receive-side checker for the heartbeat/divided-clock waveform produced by the clock divider.
- Synchronises an incoming beat, measures its period and high time in clk cycles, and compares both against expected values within a tolerance.
- Reports lock, loss-of-beat and a saturating error count; sits in the system-health logic next to the divider.

Parameters:
- EXP_PERIOD, 50000, expected clk cycles between consecutive beat rising edges
- EXP_ON, 20000, expected clk cycles beat stays high
- TOL, 8, allowed +/- deviation in cycles for both measurements
- LOCK_COUNT, 4, consecutive good periods required to declare lock
- CNT_W, 20, measurement counter width; must hold EXP_PERIOD+TOL+1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  monitor enable; 0 forces IDLE
- beat_in  in  1  heartbeat input, asynchronous to clk
- locked  out  1  high while in LOCKED
- lost  out  1  high while in LOST
- meas_valid  out  1  one-cycle pulse when period_meas/on_meas update
- period_meas  out  CNT_W  last measured period
- on_meas  out  CNT_W  last measured high time
- err_count  out  8  count of bad periods plus timeouts, saturates at 255

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, all counters 0, sync flops 0, state IDLE.
- Sync: 2-flop synchroniser (s1, s2) plus a history flop s3. rise = s2 & ~s3; fall = ~s2 & s3. Input edge to rise/fall pulse latency is 3 clk.
- Period counter pcnt:
  - loads 1 on rise;
  - otherwise increments, saturating at all-ones.
  - On rise, when not in ACQUIRE, period_meas <= pcnt.
- High counter hcnt:
  - loads 1 on rise;
  - increments while s2=1;
  - on fall, on_meas <= hcnt.
- meas_valid pulses on the cycle after a rise that captured a period.
- good: |period - EXP_PERIOD| <= TOL and |on_meas - EXP_ON| <= TOL. The on_meas used is the high phase captured within that period. Compute with CNT_W+1 signed differences, no wrap.
- timeout: pcnt == EXP_PERIOD+TOL+1 with no rise, evaluated in MEASURE or LOCKED.
- FSM states and transitions:
  - IDLE: when enable=1 -> ACQUIRE.
  - ACQUIRE: waits for the first rise (no capture); counters start; -> MEASURE, good_cnt=0.
  - MEASURE, on each rise:
    - good: good_cnt++; when it reaches LOCK_COUNT -> LOCKED.
    - bad: good_cnt=0, err_count++, stay in MEASURE.
    - timeout: -> LOST, err_count++.
  - LOCKED:
    - bad rise: -> MEASURE, good_cnt=0, err_count++.
    - timeout: -> LOST, err_count++.
  - LOST: on the next rise -> MEASURE, good_cnt=0, no capture.
  - enable=0 from any state -> IDLE next cycle. Counters and good_cnt clear; period_meas, on_meas and err_count hold.
- Simultaneous events:
  - rise on the same cycle timeout would fire: rise wins, no timeout.
  - rise and fall in the same cycle cannot occur, because a single synchronised bit is used.
- Beat stuck high or low: no rise, so timeout -> LOST.
- err_count does not wrap at 255.
- locked = (state==LOCKED); lost = (state==LOST); both registered from state.

Decomposition:
- Package heartbeat_pkg:
  - state enum: IDLE, ACQUIRE, MEASURE, LOCKED, LOST;
  - ERR_W=8 constant;
  - abs-difference-within-tolerance function.
- One natural sub-module: beat_sync_edge, the 2-flop synchroniser plus rise/fall detector, reusable elsewhere.

Test Plan:
- All scenarios use EXP_PERIOD=20, EXP_ON=8, TOL=1, LOCK_COUNT=3.
- Reset and enable: reset=0 for 5 cycles, then enable=1 with beat at 20/8 -> all outputs 0 during reset. locked rises after the 4th rise: 1 acquire plus 3 good periods. period_meas=20, on_meas=8, err_count=0.
- Tolerance edges: periods 19 and 21, on 9 -> stays locked. A period of 22 -> drops to MEASURE, err_count=1, relocks after 3 further good periods.
- Stuck beat: beat held low after lock -> lost=1 exactly when pcnt reaches 22; err_count increments by 1. Beat then resumes -> MEASURE, then LOCKED after 4 rises.
- Wrong duty: period 20 with on 5 -> never locks; err_count increments each period and saturates at 255 after 255 bad periods.
- Enable drop mid-lock: enable=0 for 3 cycles -> locked=0 next cycle, state IDLE, period_meas holds 20. Re-enable -> relocks in 4 rises.
- Async reset mid-LOCKED (asserted between clk edges) -> outputs 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/heartbeat_pkg.sv
// Shared state encoding, widths and tolerance helper for the heartbeat monitor.
package heartbeat_pkg;

    localparam int ERR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ACQUIRE,
        MEASURE,
        LOCKED,
        LOST
    } state_t;

    // True when a signed measurement-minus-expected difference lies within +/- tol.
    function automatic logic within_tol(input int diff, input int tol);
        return (diff <= tol) && (diff >= -tol);
    endfunction

endpackage

// File: rtl/beat_sync_edge.sv
// Two-flop synchroniser plus history flop for an asynchronous level input,
// producing the synchronised level and single-cycle rise/fall pulses.
module beat_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign level = s2_reg;
    assign rise  = s2_reg & ~s3_reg;
    assign fall  = ~s2_reg & s3_reg;

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat receive checker: measures beat period and high time in clk cycles,
// judges them against expected values and tracks lock, loss and error count.
module heartbeat_monitor
    import heartbeat_pkg::*;
#(
    parameter int EXP_PERIOD = 50000,
    parameter int EXP_ON     = 20000,
    parameter int TOL        = 8,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             beat_in,
    output logic             locked,
    output logic             lost,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_meas,
    output logic [CNT_W-1:0] on_meas,
    output logic [ERR_W-1:0] err_count
);
    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam int CW1  = CNT_W + 1;
    localparam logic [CNT_W-1:0]      TIMEOUT_CNT = CNT_W'(EXP_PERIOD + TOL + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX     = '1;
    localparam logic signed [CNT_W:0] EXP_P_S     = CW1'(EXP_PERIOD);
    localparam logic signed [CNT_W:0] EXP_ON_S    = CW1'(EXP_ON);

    state_t            state_reg, state_next;
    logic [GC_W-1:0]   gc_reg, gc_next;
    logic [CNT_W-1:0]  pcnt_reg;
    logic [CNT_W-1:0]  hcnt_reg;
    logic              err_inc;

    logic              level;
    logic              rise;
    logic              fall;

    logic              active;
    logic              capture;
    logic              good;
    logic              timeout;
    logic signed [CNT_W:0] period_diff;
    logic signed [CNT_W:0] on_diff;

    beat_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (beat_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // One extra bit keeps the differences signed without wrapping.
    assign period_diff = $signed({1'b0, pcnt_reg}) - EXP_P_S;
    assign on_diff     = $signed({1'b0, on_meas}) - EXP_ON_S;
    assign good        = within_tol(int'(period_diff), TOL) && within_tol(int'(on_diff), TOL);

    assign active  = (state_reg == MEASURE) || (state_reg == LOCKED);
    assign capture = enable && active && rise;
    assign timeout = active && !rise && (pcnt_reg == TIMEOUT_CNT);

    always_comb begin
        state_next = state_reg;
        gc_next    = gc_reg;
        err_inc    = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            gc_next    = '0;
        end else begin
            case (state_reg)
                IDLE: state_next = ACQUIRE;
                ACQUIRE: begin
                    if (rise) begin
                        state_next = MEASURE;
                        gc_next    = '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        if (good) begin
                            gc_next = gc_reg + GC_W'(1);
                            if (gc_next == GC_W'(LOCK_COUNT)) state_next = LOCKED;
                        end else begin
                            gc_next = '0;
                            err_inc = 1'b1;
                        end
                    end else if (timeout) begin
                        state_next = LOST;
                        err_inc    = 1'b1;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (!good) begin
                            state_next = MEASURE;
                            gc_next    = '0;
                            err_inc    = 1'b1;
                        end
                    end else if (timeout) begin
                        state_next = LOST;
                        err_inc    = 1'b1;
                    end
                end
                LOST: begin
                    if (rise) begin
                        state_next = MEASURE;
                        gc_next    = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            gc_reg      <= '0;
            pcnt_reg    <= '0;
            hcnt_reg    <= '0;
            locked      <= 1'b0;
            lost        <= 1'b0;
            meas_valid  <= 1'b0;
            period_meas <= '0;
            on_meas     <= '0;
            err_count   <= '0;
        end else begin
            state_reg  <= state_next;
            gc_reg     <= gc_next;
            locked     <= (state_next == LOCKED);
            lost       <= (state_next == LOST);
            meas_valid <= capture;

            if (capture) period_meas <= pcnt_reg;
            if (enable && fall && state_reg != IDLE && state_reg != ACQUIRE) on_meas <= hcnt_reg;
            if (err_inc && err_count != '1) err_count <= err_count + ERR_W'(1);

            if (!enable || state_reg == IDLE) begin
                pcnt_reg <= '0;
                hcnt_reg <= '0;
            end else begin
                if (rise)                      pcnt_reg <= CNT_W'(1);
                else if (pcnt_reg != CNT_MAX)  pcnt_reg <= pcnt_reg + CNT_W'(1);
                if (rise)                               hcnt_reg <= CNT_W'(1);
                else if (level && hcnt_reg != CNT_MAX)  hcnt_reg <= hcnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Self-checking bench for heartbeat_monitor using an event-level reference model
// that is updated once per beat rising edge.
module tb_heartbeat_monitor;
    localparam int EP = 20, EO = 8, TL = 1, LC = 3, CW = 20;
    localparam int SYNC_LAT = 3;
    localparam int TO_CNT   = EP + TL + 1;
    localparam int M_IDLE = 0, M_ACQ = 1, M_MEAS = 2, M_LOCK = 3, M_LOST = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          beat_in = 1'b0;
    logic          locked, lost, meas_valid;
    logic [CW-1:0] period_meas, on_meas;
    logic [7:0]    err_count;

    int total = 0;
    int bad = 0;

    int m_mode = M_IDLE;
    int m_gc = 0, m_err = 0, m_pm = 0, m_om = 0, m_last_p = 0;
    bit m_valid = 1'b0;

    heartbeat_monitor #(
        .EXP_PERIOD (EP),
        .EXP_ON     (EO),
        .TOL        (TL),
        .LOCK_COUNT (LC),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .beat_in     (beat_in),
        .locked      (locked),
        .lost        (lost),
        .meas_valid  (meas_valid),
        .period_meas (period_meas),
        .on_meas     (on_meas),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Applies the rules for one beat rising edge, judging the period that just ended.
    task automatic model_rise();
        bit good;
        m_valid = 1'b0;
        if ((m_mode == M_MEAS || m_mode == M_LOCK) && m_last_p > TO_CNT) begin
            m_err  = (m_err < 255) ? m_err + 1 : 255;
            m_mode = M_LOST;
        end
        if (m_mode == M_ACQ || m_mode == M_LOST) begin
            m_mode = M_MEAS;
            m_gc   = 0;
        end else if (m_mode == M_MEAS || m_mode == M_LOCK) begin
            m_valid = 1'b1;
            m_pm    = m_last_p;
            good    = (iabs(m_last_p - EP) <= TL) && (iabs(m_om - EO) <= TL);
            if (!good) begin
                m_err  = (m_err < 255) ? m_err + 1 : 255;
                m_mode = M_MEAS;
                m_gc   = 0;
            end else if (m_mode == M_MEAS) begin
                m_gc++;
                if (m_gc >= LC) m_mode = M_LOCK;
            end
        end
    endtask

    // One beat: high for 'on' cycles, low for the remainder of 'p' cycles.
    task automatic beat_period(input int p, input int on);
        beat_in = 1'b1;
        model_rise();
        for (int i = 0; i < p; i++) begin
            @(posedge clk); #1;
            if (i == on - 1) beat_in = 1'b0;
            if (i == SYNC_LAT - 1) begin
                total++;
                if (meas_valid !== m_valid) begin
                    bad++;
                    $display("FAIL rise_meas_valid t=%0t got=%0b want=%0b", $time, meas_valid, m_valid);
                end
                total++;
                if (period_meas !== CW'(m_pm)) begin
                    bad++;
                    $display("FAIL rise_period_meas t=%0t got=%0d want=%0d", $time, period_meas, m_pm);
                end
                total++;
                if (on_meas !== CW'(m_om)) begin
                    bad++;
                    $display("FAIL rise_on_meas t=%0t got=%0d want=%0d", $time, on_meas, m_om);
                end
                total++;
                if (locked !== (m_mode == M_LOCK) || lost !== 1'b0) begin
                    bad++;
                    $display("FAIL rise_lock_state t=%0t got locked=%0b lost=%0b want locked=%0b lost=0",
                             $time, locked, lost, (m_mode == M_LOCK));
                end
                total++;
                if (err_count !== 8'(m_err)) begin
                    bad++;
                    $display("FAIL rise_err_count t=%0t got=%0d want=%0d", $time, err_count, m_err);
                end
            end
            if (i == SYNC_LAT) begin
                total++;
                if (meas_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL meas_valid_pulse t=%0t got=%0b want=0", $time, meas_valid);
                end
            end
        end
        m_om     = on;
        m_last_p = p;
        total++;
        if (on_meas !== CW'(m_om)) begin
            bad++;
            $display("FAIL fall_on_meas t=%0t got=%0d want=%0d", $time, on_meas, m_om);
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if ({locked, lost, meas_valid, period_meas, on_meas, err_count} !== '0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got l=%0b lo=%0b v=%0b p=%0d o=%0d e=%0d want all 0",
                         c, locked, lost, meas_valid, period_meas, on_meas, err_count);
            end
        end
        reset  = 1'b1;
        enable = 1'b1;
        m_mode = M_ACQ;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        repeat (4) beat_period(20, 8);
        total++;
        if (locked !== 1'b1 || period_meas !== CW'(20) || on_meas !== CW'(8) || err_count !== 8'd0) begin
            bad++;
            $display("FAIL first_lock got l=%0b p=%0d o=%0d e=%0d want l=1 p=20 o=8 e=0",
                     locked, period_meas, on_meas, err_count);
        end
    endtask

    task automatic test_tolerance();
        beat_period(19, 9);
        beat_period(21, 9);
        beat_period(20, 7);
        beat_period(19, 8);
        beat_period(21, 7);
        beat_period(22, 8);
        repeat (5) beat_period(20, 8);
        total++;
        if (locked !== 1'b1 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL tolerance_relock got l=%0b e=%0d want l=1 e=1", locked, err_count);
        end
    endtask

    task automatic test_stuck();
        int e;
        int t_lost;
        e      = m_last_p;
        t_lost = SYNC_LAT + TO_CNT;
        for (int k = e + 1; k <= t_lost + 5; k++) begin
            @(posedge clk); #1;
            if (k == t_lost - 1) begin
                total++;
                if (lost !== 1'b0) begin
                    bad++;
                    $display("FAIL stuck_early_lost edge=%0d got=%0b want=0", k, lost);
                end
            end
            if (k == t_lost) begin
                m_err  = (m_err < 255) ? m_err + 1 : 255;
                m_mode = M_LOST;
                total++;
                if (lost !== 1'b1 || locked !== 1'b0 || err_count !== 8'(m_err)) begin
                    bad++;
                    $display("FAIL stuck_lost edge=%0d got lost=%0b locked=%0b e=%0d want 1 0 %0d",
                             k, lost, locked, err_count, m_err);
                end
            end
        end
        repeat (4) beat_period(20, 8);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL stuck_relock got=%0b want=1", locked);
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        m_mode = M_IDLE;
        m_gc   = 0;
        @(posedge clk); #1;
        total++;
        if (locked !== 1'b0 || lost !== 1'b0 || period_meas !== CW'(20) || err_count !== 8'(m_err)) begin
            bad++;
            $display("FAIL enable_drop got l=%0b lo=%0b p=%0d e=%0d want 0 0 20 %0d",
                     locked, lost, period_meas, err_count, m_err);
        end
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b1;
        m_mode = M_ACQ;
        repeat (2) @(posedge clk);
        #1;
        repeat (4) beat_period(20, 8);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL enable_relock got=%0b want=1", locked);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            beat_period(int'($urandom_range(24, 17)), int'($urandom_range(11, 5)));
        end
    endtask

    task automatic test_duty_saturation();
        int locks_seen;
        locks_seen = 0;
        for (int n = 0; n < 260; n++) begin
            beat_period(20, 5);
            if (n > 0 && locked === 1'b1) locks_seen++;
        end
        total++;
        if (locks_seen != 0) begin
            bad++;
            $display("FAIL duty_never_locks got=%0d lock periods want=0", locks_seen);
        end
        total++;
        if (err_count !== 8'd255) begin
            bad++;
            $display("FAIL err_saturate got=%0d want=255", err_count);
        end
    endtask

    task automatic test_async_reset();
        repeat (4) beat_period(20, 8);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_lock got=%0b want=1", locked);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        total++;
        if ({locked, lost, meas_valid, period_meas, on_meas, err_count} !== '0) begin
            bad++;
            $display("FAIL async_reset t=%0t got l=%0b p=%0d o=%0d e=%0d want all 0",
                     $time, locked, period_meas, on_meas, err_count);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_mode = M_ACQ;
        m_gc = 0; m_err = 0; m_pm = 0; m_om = 0;
        repeat (2) @(posedge clk);
        #1;
        repeat (4) beat_period(20, 8);
        total++;
        if (locked !== 1'b1 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL post_reset_lock got l=%0b e=%0d want l=1 e=0", locked, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tolerance();
        test_stuck();
        test_enable_drop();
        test_random();
        test_duty_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
